spi_flash_responder: RTL
========================

Name: spi_flash_responder

Overview:
SPI-mode-0 responder that emulates the command subset of a serial NOR flash used by the bootloader's SPI bridge endpoint: ID, status, read, write-enable and page program. It is the far end of spi_cs/spi_sck/spi_mosi/spi_miso and sits in simulation benches and flash-less FPGA builds. A single-port byte memory interface backs it. All SPI inputs are asynchronous to clk_48mhz and are oversampled.

Parameters:
ADDR_W, 24, backing-store address width; upper command address bits are ignored.
JEDEC_ID, 24'hEF4016, returned MSB-first by 0x9F.

Ports:
clk_48mhz  in  1  system clock
reset_n  in  1  reset; synchronous, active-low
spi_cs_b  in  1  chip select, active low
spi_sck  in  1  serial clock; max clk_48mhz/8
spi_mosi  in  1  serial data in
spi_miso  out  1  serial data out
spi_miso_oe  out  1  1 while selected and driving
mem_addr  out  ADDR_W  backing-store byte address
mem_rd_en  out  1  read strobe; data valid on mem_rd_data exactly 1 cycle later
mem_rd_data  in  8  read data
mem_wr_en  out  1  write strobe, 1 cycle
mem_wr_data  out  8  write data

Behaviour:
- Reset: spi_miso=0, spi_miso_oe=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, WEL=0, power-down=0, state IDLE.
- Input sync: 2-flop synchronisers on cs_b, sck, mosi. Edge detect on synced sck. MOSI sampled on the detected rise. MISO shifted on the detected fall. All edges are ignored while synced cs_b=1.
- Framing: a falling edge on cs_b clears the 3-bit bit counter, and the state becomes CMD. A rising edge on cs_b returns to IDLE from any state, discards a partial byte, sets spi_miso_oe=0, and applies deferred effects.
- States: IDLE, CMD, ADDR (3 bytes MSB-first), READ, PP, TX_FIXED, IGNORE.
- Commands, decoded on the 8th rise of CMD:
  - 0x9F: TX_FIXED with JEDEC_ID, 3 bytes, then 0x00.
  - 0x05: TX_FIXED with status {6'b0, WEL, 1'b0}, repeated every byte.
  - 0x06: set WEL at CS rise.
  - 0x04: clear WEL at CS rise.
  - 0x03: ADDR then READ.
  - 0x02: ADDR then PP, but only if WEL=1; otherwise IGNORE.
  - 0xB9: enter power-down at CS rise.
  - 0xAB: leave power-down at CS rise.
  - Anything else: IGNORE.
- Power-down: every command except 0xAB goes to IGNORE.
- READ:
  - On the 8th rise of address byte 3, pulse mem_rd_en with the latched address.
  - Load mem_rd_data into the TX shift register the next cycle.
  - On each subsequent 8th data rise, prefetch addr+1. The address wraps at 2^ADDR_W.
  - The MSB is driven on the first fall after load.
- PP:
  - Each complete received byte produces one mem_wr_en pulse at {addr[ADDR_W-1:8], low}.
  - The low byte increments mod 256, so writing wraps within the page.
  - The device writes the received byte directly; it does not AND with old data.
  - WEL clears at CS rise if at least one PP byte was accepted or PP was entered.
- TX timing: after a command/address byte, spi_miso_oe=1 from the first fall. The first output bit is valid before the next rise; this is guaranteed by the ≥4-clock half period.
- spi_miso holds its value between falls. spi_miso=0 whenever it is not driving.
- Simultaneous events:
  - A CS rise in the same cycle as an 8th SCK rise drops the byte.
  - A mem_rd_en in flight at CS rise completes, but its data is discarded.
- reset_n low mid-transfer forces reset values. A transfer must restart with a fresh CS fall.

Decomposition:
- Package spi_flash_pkg holds:
  - command opcode constants: CMD_READ, CMD_PP, CMD_WREN, CMD_WRDI, CMD_RDSR, CMD_JEDEC, CMD_PD, CMD_RPD;
  - the state enum;
  - status bit indices.
- One sub-module, spi_flash_rx_sync, provides the synchronisers and sck rise/fall and cs fall/rise pulse outputs.

Test Plan:
- 0x9F then 4 dummy bytes -> MISO returns EF 40 16 00; no mem strobes.
- 0x05 → 0x00; 0x06 then 0x05 → 0x02; 0x04 then 0x05 → 0x00.
- Memory preloaded with 0x00FFFE=A5, 0x00FFFF=5A, 0x010000=C3; 0x03 00 FF FE plus 3 dummies -> A5 5A C3, with 3 mem_rd_en pulses at ascending addresses.
- PP without WREN: 0x02 00 00 10 11 22 -> no mem_wr_en. Then WREN, PP 0x02 00 01 FE 11 22 33 -> writes at 0x0001FE, 0x0001FF, 0x000100; status afterwards is 0x00.
- 0xB9, then 0x9F -> MISO undriven (oe=0). Then 0xAB, 0x9F -> EF 40 16.
- CS rises after 5 bits of a PP data byte -> no write. reset_n low mid-READ -> spi_miso_oe=0 and WEL=0 next cycle, and the next 0x05 returns 0x00.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash responder: opcodes, FSM states, and status bits.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_PP    = 8'h02;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_PD    = 8'hB9;
    localparam logic [7:0] CMD_RPD   = 8'hAB;

    localparam int unsigned SR_WIP_BIT = 0;
    localparam int unsigned SR_WEL_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_ADDR     = 3'd2,
        ST_READ     = 3'd3,
        ST_PP       = 3'd4,
        ST_TX_FIXED = 3'd5,
        ST_IGNORE   = 3'd6
    } state_e;

    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] sr;
        sr             = 8'h00;
        sr[SR_WIP_BIT] = 1'b0;
        sr[SR_WEL_BIT] = wel;
        return sr;
    endfunction

endpackage

// File: rtl/spi_flash_rx_sync.sv
// Two-flop synchronisers for the SPI pins plus edge pulses; sck edges are masked while deselected.
module spi_flash_rx_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic cs_b_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic mosi_o,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);

    logic [1:0] cs_sync_q;
    logic [1:0] sck_sync_q;
    logic [1:0] mosi_sync_q;
    logic       cs_prev_q;
    logic       sck_prev_q;

    // cs history resets low so a select already held through reset never looks like a fresh fall
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cs_sync_q   <= 2'b00;
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], cs_b_i};
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            cs_prev_q   <= cs_sync_q[1];
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    assign mosi_o     = mosi_sync_q[1];
    assign sck_rise_o = ~cs_sync_q[1] & ~sck_prev_q &  sck_sync_q[1];
    assign sck_fall_o = ~cs_sync_q[1] &  sck_prev_q & ~sck_sync_q[1];
    assign cs_fall_o  =  cs_prev_q & ~cs_sync_q[1];
    assign cs_rise_o  = ~cs_prev_q &  cs_sync_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator (ID, status, read, WREN/WRDI, page program, power-down)
// backed by a single-port byte memory.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk_48mhz,
    input  logic              reset_n,
    input  logic              spi_cs_b,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    logic mosi_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic cs_fall_s;
    logic cs_rise_s;

    spi_flash_rx_sync u_sync (
        .clk_i      (clk_48mhz),
        .rst_n_i    (reset_n),
        .cs_b_i     (spi_cs_b),
        .sck_i      (spi_sck),
        .mosi_i     (spi_mosi),
        .mosi_o     (mosi_s),
        .sck_rise_o (sck_rise_s),
        .sck_fall_o (sck_fall_s),
        .cs_fall_o  (cs_fall_s),
        .cs_rise_o  (cs_rise_s)
    );

    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        rx_sr_q;
    logic [7:0]        tx_sr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        addr_cnt_q;
    logic              is_pp_q;
    logic [7:0]        pp_low_q;
    logic [1:0]        fix_idx_q;
    logic              fix_jedec_q;
    logic              wel_q;
    logic              pd_q;
    logic              set_wel_q;
    logic              clr_wel_q;
    logic              pp_seen_q;
    logic              enter_pd_q;
    logic              exit_pd_q;
    logic              rd_load_q;
    logic              miso_q;
    logic              oe_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [7:0]        wr_data_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [7:0]        rx_byte_d;
    logic              byte_done_d;
    logic [ADDR_W-1:0] addr_shift_d;
    logic [ADDR_W-1:0] addr_inc_d;
    logic [1:0]        fix_idx_d;

    assign rx_byte_d    = {rx_sr_q, mosi_s};
    assign byte_done_d  = sck_rise_s && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
    assign addr_shift_d = {addr_q[ADDR_W-9:0], rx_byte_d};
    assign addr_inc_d   = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign fix_idx_d    = (fix_idx_q == 2'd3) ? 2'd3 : fix_idx_q + 2'd1;

    function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    jedec_byte = JEDEC_ID[23:16];
            2'd1:    jedec_byte = JEDEC_ID[15:8];
            2'd2:    jedec_byte = JEDEC_ID[7:0];
            default: jedec_byte = 8'h00;
        endcase
    endfunction

    // Protocol FSM: framing, command decode, shifting and memory strobes
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 7'd0;
            tx_sr_q     <= 8'h00;
            addr_q      <= '0;
            addr_cnt_q  <= 2'd0;
            is_pp_q     <= 1'b0;
            pp_low_q    <= 8'h00;
            fix_idx_q   <= 2'd0;
            fix_jedec_q <= 1'b0;
            wel_q       <= 1'b0;
            pd_q        <= 1'b0;
            set_wel_q   <= 1'b0;
            clr_wel_q   <= 1'b0;
            pp_seen_q   <= 1'b0;
            enter_pd_q  <= 1'b0;
            exit_pd_q   <= 1'b0;
            rd_load_q   <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= 8'h00;
            mem_addr_q  <= '0;
        end else begin
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_load_q <= rd_en_q;
            if (cs_rise_s) begin
                // Deselect wins over any same-cycle sck edge; in-flight read data is dropped
                state_q    <= ST_IDLE;
                bit_cnt_q  <= 3'd0;
                oe_q       <= 1'b0;
                miso_q     <= 1'b0;
                rd_load_q  <= 1'b0;
                if (set_wel_q) begin
                    wel_q <= 1'b1;
                end else if (clr_wel_q || pp_seen_q) begin
                    wel_q <= 1'b0;
                end
                if (enter_pd_q) begin
                    pd_q <= 1'b1;
                end else if (exit_pd_q) begin
                    pd_q <= 1'b0;
                end
                set_wel_q  <= 1'b0;
                clr_wel_q  <= 1'b0;
                pp_seen_q  <= 1'b0;
                enter_pd_q <= 1'b0;
                exit_pd_q  <= 1'b0;
            end else if (cs_fall_s) begin
                state_q    <= ST_CMD;
                bit_cnt_q  <= 3'd0;
                addr_q     <= '0;
                addr_cnt_q <= 2'd0;
                oe_q       <= 1'b0;
                miso_q     <= 1'b0;
                set_wel_q  <= 1'b0;
                clr_wel_q  <= 1'b0;
                pp_seen_q  <= 1'b0;
                enter_pd_q <= 1'b0;
                exit_pd_q  <= 1'b0;
            end else begin
                if (rd_load_q) begin
                    tx_sr_q <= mem_rd_data;
                end
                if (sck_rise_s && (state_q != ST_IDLE)) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    rx_sr_q   <= rx_byte_d[6:0];
                end
                if (byte_done_d) begin
                    case (state_q)
                        ST_CMD: begin
                            if (pd_q && (rx_byte_d != CMD_RPD)) begin
                                state_q <= ST_IGNORE;
                            end else begin
                                case (rx_byte_d)
                                    CMD_JEDEC: begin
                                        state_q     <= ST_TX_FIXED;
                                        fix_jedec_q <= 1'b1;
                                        fix_idx_q   <= 2'd0;
                                        tx_sr_q     <= jedec_byte(2'd0);
                                    end
                                    CMD_RDSR: begin
                                        state_q     <= ST_TX_FIXED;
                                        fix_jedec_q <= 1'b0;
                                        tx_sr_q     <= status_byte(wel_q);
                                    end
                                    CMD_WREN: begin
                                        state_q   <= ST_IGNORE;
                                        set_wel_q <= 1'b1;
                                    end
                                    CMD_WRDI: begin
                                        state_q   <= ST_IGNORE;
                                        clr_wel_q <= 1'b1;
                                    end
                                    CMD_READ: begin
                                        state_q <= ST_ADDR;
                                        is_pp_q <= 1'b0;
                                    end
                                    CMD_PP: begin
                                        state_q <= wel_q ? ST_ADDR : ST_IGNORE;
                                        is_pp_q <= 1'b1;
                                    end
                                    CMD_PD: begin
                                        state_q    <= ST_IGNORE;
                                        enter_pd_q <= 1'b1;
                                    end
                                    CMD_RPD: begin
                                        state_q   <= ST_IGNORE;
                                        exit_pd_q <= 1'b1;
                                    end
                                    default: state_q <= ST_IGNORE;
                                endcase
                            end
                        end
                        ST_ADDR: begin
                            addr_q     <= addr_shift_d;
                            addr_cnt_q <= addr_cnt_q + 2'd1;
                            if (addr_cnt_q == 2'd2) begin
                                if (is_pp_q) begin
                                    state_q   <= ST_PP;
                                    pp_low_q  <= rx_byte_d;
                                    pp_seen_q <= 1'b1;
                                end else begin
                                    state_q    <= ST_READ;
                                    rd_en_q    <= 1'b1;
                                    mem_addr_q <= addr_shift_d;
                                end
                            end
                        end
                        ST_READ: begin
                            addr_q     <= addr_inc_d;
                            mem_addr_q <= addr_inc_d;
                            rd_en_q    <= 1'b1;
                        end
                        ST_PP: begin
                            wr_en_q    <= 1'b1;
                            wr_data_q  <= rx_byte_d;
                            mem_addr_q <= {addr_q[ADDR_W-1:8], pp_low_q};
                            pp_low_q   <= pp_low_q + 8'd1;
                        end
                        ST_TX_FIXED: begin
                            if (fix_jedec_q) begin
                                fix_idx_q <= fix_idx_d;
                                tx_sr_q   <= jedec_byte(fix_idx_d);
                            end else begin
                                tx_sr_q   <= status_byte(wel_q);
                            end
                        end
                        default: ;
                    endcase
                end
                if (sck_fall_s && ((state_q == ST_READ) || (state_q == ST_TX_FIXED))) begin
                    oe_q    <= 1'b1;
                    miso_q  <= tx_sr_q[7];
                    tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

endmodule
